// File: rtl/instr_fetch_decode_pkg.sv
// rtl/instr_fetch_decode_pkg.sv - shared CPU constants: instruction field layout, fetch states, reset PC
package instr_fetch_decode_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPC_MSB   = 31;
    localparam int OPC_W     = 6;
    localparam int RS_MSB    = 25;
    localparam int RT_MSB    = 20;
    localparam int RD_MSB    = 15;
    localparam int SHAMT_MSB = 10;
    localparam int REG_W     = 5;
    localparam int FUNCT_W   = 6;
    localparam int IMM_W     = 16;
    localparam int JADDR_W   = 26;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// rtl/instr_fetch_decode_if.sv - instruction-memory request/grant/read-data port
interface instr_fetch_decode_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_decode_ifid_reg.sv
// rtl/instr_fetch_decode_ifid_reg.sv - IF/ID pipeline register with stall/flush and decode field split
module instr_fetch_decode_ifid_reg
    import instr_fetch_decode_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [31:0]         instr,
    input  logic [31:0]         pc,
    input  logic                stall,
    input  logic                flush,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_pc4,
    output logic [OPC_W-1:0]    id_opcode,
    output logic [REG_W-1:0]    id_rs,
    output logic [REG_W-1:0]    id_rt,
    output logic [REG_W-1:0]    id_rd,
    output logic [REG_W-1:0]    id_shamt,
    output logic [FUNCT_W-1:0]  id_funct,
    output logic [IMM_W-1:0]    id_immediate,
    output logic [JADDR_W-1:0]  id_jaddr
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;

    // Without a stall the held instruction moves on to decode, leaving a bubble
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (load) begin
            instr_d = instr;
            pc_d    = pc;
            pc4_d   = pc + 32'd4;
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (!stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            pc4_q   <= 32'd4;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign id_valid     = valid_q;
    assign id_pc        = pc_q;
    assign id_pc4       = pc4_q;
    assign id_opcode    = instr_q[OPC_MSB -: OPC_W];
    assign id_rs        = instr_q[RS_MSB -: REG_W];
    assign id_rt        = instr_q[RT_MSB -: REG_W];
    assign id_rd        = instr_q[RD_MSB -: REG_W];
    assign id_shamt     = instr_q[SHAMT_MSB -: REG_W];
    assign id_funct     = instr_q[FUNCT_W-1:0];
    assign id_immediate = instr_q[IMM_W-1:0];
    assign id_jaddr     = instr_q[JADDR_W-1:0];

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - fetch FSM, PC and skid buffer feeding the IF/ID register
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_decode_if.master   imem,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_pc4,
    output logic [OPC_W-1:0]       id_opcode,
    output logic [REG_W-1:0]       id_rs,
    output logic [REG_W-1:0]       id_rt,
    output logic [REG_W-1:0]       id_rd,
    output logic [REG_W-1:0]       id_shamt,
    output logic [FUNCT_W-1:0]     id_funct,
    output logic [IMM_W-1:0]       id_immediate,
    output logic [JADDR_W-1:0]     id_jaddr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         discard_q, discard_d;
    logic [31:0]  skid_q, skid_d;
    logic         load;
    logic [31:0]  load_instr;
    logic [31:0]  redir_pc;

    assign redir_pc = redirect_pc & ~32'h3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        discard_d  = discard_q;
        skid_d     = skid_q;
        load       = 1'b0;
        load_instr = imem.imem_rdata;
        unique case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (req_q && imem.imem_gnt) begin
                    state_d   = WAIT;
                    req_d     = 1'b0;
                    // Redirect alongside the grant: the accepted fetch is already stale
                    discard_d = redirect;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (discard_q || redirect) begin
                        state_d   = FETCH;
                        req_d     = 1'b1;
                        discard_d = 1'b0;
                    end else if (!stall) begin
                        load    = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end else begin
                        skid_d  = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = skid_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                    req_d      = 1'b1;
                end
            end
            default: begin
                state_d = FETCH;
                req_d   = 1'b0;
            end
        endcase
        if (redirect) begin
            pc_d = redir_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            skid_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            discard_q <= discard_d;
            skid_q    <= skid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    instr_fetch_decode_ifid_reg u_ifid (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .instr        (load_instr),
        .pc           (pc_q),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_pc4       (id_pc4),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_shamt     (id_shamt),
        .id_funct     (id_funct),
        .id_immediate (id_immediate),
        .id_jaddr     (id_jaddr)
    );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed vector bench for the fetch front end and IF/ID register
module tb_instr_fetch_decode;
    import instr_fetch_decode_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_decode_if bus ();

    logic         stall, flush, redirect;
    logic [31:0]  redirect_pc;
    logic         id_valid;
    logic [31:0]  id_pc, id_pc4;
    logic [5:0]   id_opcode, id_funct;
    logic [4:0]   id_rs, id_rt, id_rd, id_shamt;
    logic [15:0]  id_immediate;
    logic [25:0]  id_jaddr;

    instr_fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_pc4       (id_pc4),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_shamt     (id_shamt),
        .id_funct     (id_funct),
        .id_immediate (id_immediate),
        .id_jaddr     (id_jaddr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] word;
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] pc;
        logic [5:0]  opc;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] ja;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) step();
        chk("req_within_budget", {31'h0, bus.imem_req}, 32'h1);
    endtask

    task automatic grant(input int gnt_wait, input logic [31:0] exp_addr);
        wait_req();
        chk("fetch_addr", bus.imem_addr, exp_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            step();
            chk("dma_req_held", {31'h0, bus.imem_req}, 32'h1);
            chk("dma_addr_stable", bus.imem_addr, exp_addr);
            chk("dma_id_valid", {31'h0, id_valid}, 32'h0);
        end
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("req_drop_after_gnt", {31'h0, bus.imem_req}, 32'h0);
    endtask

    task automatic respond(input int rv_wait, input logic [31:0] word);
        for (int i = 1; i < rv_wait; i++) step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
    endtask

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        //          word          gw rw pc     opc    rs     rt     rd     sh     fn     imm       jaddr
        vecs[0] = '{32'h3C01_1234, 0, 1, 32'd0,  6'h0F, 5'd0,  5'd1,  5'd2,  5'd8,  6'h34, 16'h1234, 26'h001_1234};
        vecs[1] = '{32'h8D28_FFFC, 0, 1, 32'd4,  6'h23, 5'd9,  5'd8,  5'd31, 5'd31, 6'h3C, 16'hFFFC, 26'h128_FFFC};
        vecs[2] = '{32'h0085_1020, 5, 3, 32'd8,  6'h00, 5'd4,  5'd5,  5'd2,  5'd0,  6'h20, 16'h1020, 26'h085_1020};
        vecs[3] = '{32'h0800_0040, 1, 2, 32'd12, 6'h02, 5'd0,  5'd0,  5'd0,  5'd1,  6'h00, 16'h0040, 26'h000_0040};
        vecs[4] = '{32'hFFFF_FFFF, 2, 1, 32'd16, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF};

        step(); step();
        chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h4);
        chk("rst_id_imm", {16'h0, id_immediate}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("req_first_edge", {31'h0, bus.imem_req}, 32'h1);

        for (int v = 0; v < 5; v++) begin
            grant(vecs[v].gnt_wait, vecs[v].pc);
            respond(vecs[v].rv_wait, vecs[v].word);
            chk("vec_id_valid", {31'h0, id_valid}, 32'h1);
            chk("vec_id_pc", id_pc, vecs[v].pc);
            chk("vec_id_pc4", id_pc4, vecs[v].pc + 32'd4);
            chk("vec_opcode", {26'h0, id_opcode}, {26'h0, vecs[v].opc});
            chk("vec_rs", {27'h0, id_rs}, {27'h0, vecs[v].rs});
            chk("vec_rt", {27'h0, id_rt}, {27'h0, vecs[v].rt});
            chk("vec_rd", {27'h0, id_rd}, {27'h0, vecs[v].rd});
            chk("vec_shamt", {27'h0, id_shamt}, {27'h0, vecs[v].sh});
            chk("vec_funct", {26'h0, id_funct}, {26'h0, vecs[v].fn});
            chk("vec_imm", {16'h0, id_immediate}, {16'h0, vecs[v].imm});
            chk("vec_jaddr", {6'h0, id_jaddr}, {6'h0, vecs[v].ja});
            chk("vec_next_addr", bus.imem_addr, vecs[v].pc + 32'd4);
        end

        // Stall across the read return: word parks in the skid buffer
        grant(0, 32'd20);
        stall = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2002_0005;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_id_valid", {31'h0, id_valid}, 32'h0);
            chk("hold_id_pc", id_pc, 32'd16);
            chk("hold_no_req", {31'h0, bus.imem_req}, 32'h0);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        chk("skid_id_valid", {31'h0, id_valid}, 32'h1);
        chk("skid_id_pc", id_pc, 32'd20);
        chk("skid_opcode", {26'h0, id_opcode}, 32'h08);
        chk("skid_rt", {27'h0, id_rt}, 32'd2);
        chk("skid_imm", {16'h0, id_immediate}, 32'h5);
        chk("skid_next_addr", bus.imem_addr, 32'd24);
        chk("skid_req", {31'h0, bus.imem_req}, 32'h1);

        // Stall holds a live instruction; flush overrides the stall
        stall = 1'b1;
        step();
        chk("stall_hold_valid", {31'h0, id_valid}, 32'h1);
        chk("stall_hold_pc", id_pc, 32'd20);
        flush = 1'b1;
        step();
        chk("flush_over_stall", {31'h0, id_valid}, 32'h0);
        stall = 1'b0;
        flush = 1'b0;

        // Redirect while waiting (misaligned target): returning word is dropped
        grant(0, 32'd24);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        chk("redir_wait_addr", bus.imem_addr, 32'h0000_0100);
        chk("redir_wait_req", {31'h0, bus.imem_req}, 32'h0);
        respond(1, 32'hDEAD_BEEF);
        chk("redir_drop_valid", {31'h0, id_valid}, 32'h0);
        chk("redir_drop_req", {31'h0, bus.imem_req}, 32'h1);
        grant(0, 32'h0000_0100);
        respond(1, 32'h3C01_1234);
        chk("redir_load_valid", {31'h0, id_valid}, 32'h1);
        chk("redir_load_pc", id_pc, 32'h0000_0100);
        chk("redir_load_pc4", id_pc4, 32'h0000_0104);

        // Redirect in the same cycle as rvalid
        grant(0, 32'h0000_0104);
        redirect        = 1'b1;
        redirect_pc     = 32'hFFFF_FFFC;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        step();
        redirect        = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        chk("same_cyc_drop_valid", {31'h0, id_valid}, 32'h0);
        chk("same_cyc_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("same_cyc_req", {31'h0, bus.imem_req}, 32'h1);

        // PC wrap at the top of the address space
        grant(0, 32'hFFFF_FFFC);
        respond(1, 32'h0000_0000);
        chk("wrap_id_valid", {31'h0, id_valid}, 32'h1);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc4", id_pc4, 32'h0);
        chk("wrap_next_addr", bus.imem_addr, 32'h0);

        // Reset mid-transaction with a read return pending
        grant(0, 32'h0);
        rst_n = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        step();
        chk("midrst_req", {31'h0, bus.imem_req}, 32'h0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
        chk("midrst_id_valid", {31'h0, id_valid}, 32'h0);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        rst_n = 1'b1;
        step();
        chk("midrst_req_rise", {31'h0, bus.imem_req}, 32'h1);
        step();
        chk("midrst_no_load", {31'h0, id_valid}, 32'h0);
        chk("midrst_addr_hold", bus.imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
